// File: rtl/ff_bank_arbiter.sv
// Round-robin arbiter and write sequencer for one shared register.
// The winner is granted, its data lands one cycle later, then grant is held HOLD cycles.
module ff_bank_arbiter #(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned WIDTH = 8,
   parameter int unsigned HOLD  = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*WIDTH-1:0]   wdata,
   input  logic                    clr,
   output logic [NREQ-1:0]         grant,
   output logic [NREQ-1:0]         ack,
   output logic [WIDTH-1:0]        q,
   output logic [$clog2(NREQ)-1:0] owner,
   output logic                    busy
);

   localparam int unsigned PW = $clog2(NREQ);
   localparam int unsigned HW = $clog2(HOLD + 1);
   localparam logic [PW-1:0]   LastIdx = PW'(NREQ - 1);
   localparam logic [NREQ-1:0] OneLsb  = NREQ'(1);

   typedef enum logic [1:0] {StIdle, StGrant, StHold} state_e;

   state_e            r_state, w_state_d;
   logic [PW-1:0]     r_ptr, w_ptr_d;
   logic [HW-1:0]     r_hcnt, w_hcnt_d;
   logic [NREQ-1:0]   r_grant, w_grant_d;
   logic [NREQ-1:0]   r_ack, w_ack_d;
   logic [WIDTH-1:0]  r_q, w_q_d;
   logic [PW-1:0]     r_owner, w_owner_d;
   logic [PW-1:0]     w_win;
   logic              w_any;

   // Two-pass scan: first set bit at or above ptr, otherwise first set bit overall.
   always_comb begin
      w_win = '0;
      w_any = 1'b0;
      for (int j = 0; j < int'(NREQ); j++) begin
         if (!w_any && req[j] && (j >= int'(r_ptr))) begin
            w_win = j[PW-1:0];
            w_any = 1'b1;
         end
      end
      for (int j = 0; j < int'(NREQ); j++) begin
         if (!w_any && req[j]) begin
            w_win = j[PW-1:0];
            w_any = 1'b1;
         end
      end
   end

   always_comb begin
      w_state_d = r_state;
      w_ptr_d   = r_ptr;
      w_hcnt_d  = r_hcnt;
      w_grant_d = r_grant;
      w_ack_d   = '0;
      w_q_d     = r_q;
      w_owner_d = r_owner;
      unique case (r_state)
         StIdle: begin
            if (clr) begin
               w_q_d = '0;
            end else if (w_any) begin
               w_grant_d = OneLsb << w_win;
               w_owner_d = w_win;
               w_state_d = StGrant;
            end
         end
         StGrant: begin
            w_q_d     = wdata[int'(r_owner)*WIDTH +: WIDTH];
            w_ack_d   = OneLsb << r_owner;
            w_hcnt_d  = HW'(HOLD);
            w_state_d = StHold;
         end
         StHold: begin
            w_hcnt_d = r_hcnt - HW'(1);
            if (r_hcnt == HW'(1)) begin
               w_grant_d = '0;
               w_ptr_d   = (r_owner == LastIdx) ? '0 : r_owner + PW'(1);
               w_state_d = StIdle;
            end
         end
         default: begin
            w_state_d = StIdle;
            w_grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= StIdle;
         r_ptr   <= '0;
         r_hcnt  <= '0;
         r_grant <= '0;
         r_ack   <= '0;
         r_q     <= '0;
         r_owner <= '0;
      end else begin
         r_state <= w_state_d;
         r_ptr   <= w_ptr_d;
         r_hcnt  <= w_hcnt_d;
         r_grant <= w_grant_d;
         r_ack   <= w_ack_d;
         r_q     <= w_q_d;
         r_owner <= w_owner_d;
      end
   end

   assign grant = r_grant;
   assign ack   = r_ack;
   assign q     = r_q;
   assign owner = r_owner;
   assign busy  = (r_state != StIdle);

endmodule

// File: tb/tb_ff_bank_arbiter.sv
// Randomised and directed bench for ff_bank_arbiter against a timeline-based reference model.
module tb_ff_bank_arbiter;

   localparam int NREQ  = 4;
   localparam int WIDTH = 8;
   localparam int HOLD  = 2;
   localparam int OW    = $clog2(NREQ);

   logic                  clk = 1'b0;
   logic                  reset;
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] wdata;
   logic                  clr;
   logic [NREQ-1:0]       grant;
   logic [NREQ-1:0]       ack;
   logic [WIDTH-1:0]      q;
   logic [OW-1:0]         owner;
   logic                  busy;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: a write is a window of HOLD+2 edges measured from the grant edge.
   bit               m_active;
   int               m_age;
   int               m_ptr;
   int               m_owner;
   logic [WIDTH-1:0] m_q;

   ff_bank_arbiter #(
      .NREQ (NREQ),
      .WIDTH(WIDTH),
      .HOLD (HOLD)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .req  (req),
      .wdata(wdata),
      .clr  (clr),
      .grant(grant),
      .ack  (ack),
      .q    (q),
      .owner(owner),
      .busy (busy)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_active = 1'b0;
      m_age    = 0;
      m_ptr    = 0;
      m_owner  = 0;
      m_q      = '0;
   endtask

   task automatic model_edge();
      if (!m_active) begin
         if (clr) begin
            m_q = '0;
         end else if (req != '0) begin
            for (int k = 0; k < NREQ; k++) begin
               if (req[(m_ptr + k) % NREQ]) begin
                  m_owner = (m_ptr + k) % NREQ;
                  break;
               end
            end
            m_active = 1'b1;
            m_age    = 0;
         end
      end else begin
         m_age++;
         if (m_age == 1) m_q = wdata[m_owner*WIDTH +: WIDTH];
         if (m_age == HOLD + 1) begin
            m_active = 1'b0;
            m_ptr    = (m_owner + 1) % NREQ;
         end
      end
   endtask

   task automatic check_outputs();
      logic [NREQ-1:0] exp_grant;
      logic [NREQ-1:0] exp_ack;
      exp_grant = m_active ? NREQ'(1 << m_owner) : '0;
      exp_ack   = (m_active && m_age == 1) ? NREQ'(1 << m_owner) : '0;
      check_eq("grant", 32'(grant), 32'(exp_grant));
      check_eq("ack", 32'(ack), 32'(exp_ack));
      check_eq("q", 32'(q), 32'(m_q));
      check_eq("owner", 32'(owner), 32'(m_owner));
      check_eq("busy", 32'(busy), 32'(m_active));
      check_eq("grant_onehot", 32'($countones(grant) <= 1), 32'd1);
   endtask

   // Called at a negedge with inputs already driven; returns at the next negedge.
   task automatic cycle();
      model_edge();
      @(posedge clk);
      #1;
      check_outputs();
      @(negedge clk);
   endtask

   task automatic idle_cycles(input int n);
      req = '0;
      clr = 1'b0;
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_grant"}, 32'(grant), 32'd0);
      check_eq({tag, "_ack"}, 32'(ack), 32'd0);
      check_eq({tag, "_q"}, 32'(q), 32'd0);
      check_eq({tag, "_owner"}, 32'(owner), 32'd0);
      check_eq({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      reset = 1'b0;
      req   = '0;
      clr   = 1'b0;
      wdata = '0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check_all_zero("reset");
      reset = 1'b1;

      // Single request from requester 1
      wdata = {8'h44, 8'h33, 8'hA5, 8'h11};
      req   = 4'b0010;
      cycle();
      check_eq("single_grant", 32'(grant), 32'h2);
      cycle();
      check_eq("single_q", 32'(q), 32'hA5);
      check_eq("single_ack", 32'(ack), 32'h2);
      req = '0;
      cycle();
      cycle();
      check_eq("single_release", 32'(busy), 32'd0);
      idle_cycles(2);

      // Continuous contention: order follows ptr, which is now 2
      wdata = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
      req   = 4'b1111;
      for (int i = 0; i < 5 * (HOLD + 2); i++) cycle();
      idle_cycles(HOLD + 2);

      // Clear priority over request
      wdata = {8'h00, 8'h00, 8'h00, 8'h3C};
      req   = 4'b0001;
      cycle();
      req = '0;
      idle_cycles(HOLD + 2);
      check_eq("clr_pre_q", 32'(q), 32'h3C);
      clr = 1'b1;
      req = 4'b0001;
      cycle();
      check_eq("clr_q", 32'(q), 32'd0);
      check_eq("clr_nogrant", 32'(grant), 32'd0);
      clr = 1'b0;
      cycle();
      check_eq("clr_then_grant", 32'(grant), 32'h1);
      req = '0;
      idle_cycles(HOLD + 3);

      // One-cycle request pulse still completes the write
      wdata = {8'h9A, 8'h5E, 8'h12, 8'h34};
      req   = 4'b0100;
      cycle();
      req = '0;
      cycle();
      check_eq("drop_q", 32'(q), 32'h5E);
      check_eq("drop_ack", 32'(ack), 32'h4);
      idle_cycles(HOLD + 2);

      // Pointer wrap after owner 3
      req = 4'b1000;
      cycle();
      req = '0;
      idle_cycles(HOLD + 2);
      req = 4'b1001;
      cycle();
      check_eq("wrap_first", 32'(grant), 32'h1);
      for (int i = 0; i < HOLD + 2; i++) cycle();
      check_eq("wrap_second", 32'(grant), 32'h8);
      idle_cycles(HOLD + 3);

      // Asynchronous reset while in HOLD, between edges
      req = 4'b0010;
      cycle();
      cycle();
      #2;
      reset = 1'b0;
      #1;
      check_all_zero("async");
      model_reset();
      @(negedge clk);
      check_all_zero("async_hold");
      reset = 1'b1;
      req   = 4'b1011;
      cycle();
      check_eq("async_first_grant", 32'(grant), 32'h1);
      idle_cycles(HOLD + 3);

      // Random traffic; requesters mostly drop after their ack
      for (int i = 0; i < 600; i++) begin
         for (int r = 0; r < NREQ; r++) begin
            if (ack[r] && ($urandom_range(0, 3) != 0)) req[r] = 1'b0;
            else if (!req[r] && ($urandom_range(0, 4) == 0)) req[r] = 1'b1;
            else if (req[r] && ($urandom_range(0, 15) == 0)) req[r] = 1'b0;
         end
         clr   = ($urandom_range(0, 9) == 0);
         wdata = {$urandom(), $urandom()};
         wdata = NREQ*WIDTH'(wdata);
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ff_bank_arbiter.md
# ff_bank_arbiter

Round-robin arbiter and write sequencer for one shared WIDTH-bit register built from the team's flip-flop cells. Up to NREQ requesters compete for write access. The winner's data is loaded in a fixed GRANT cycle, then held stable for HOLD cycles before the register is released. The block sits between game-logic producers and any consumer that reads the shared register `q`.

## Interface

Parameters:

- `NREQ`, default 4: number of requesters; the value is 2..8.
- `WIDTH`, default 8: width of the shared register.
- `HOLD`, default 2: cycles for which grant is held after the write; the value is at least 1.

Ports:

- `clk`  in  1: single system clock; all state updates on its rising edge.
- `reset`  in  1: asynchronous, active-low; clears all state immediately when low.
- `req`  in  NREQ: request lines; bit i is requester i; level-sensitive.
- `wdata`  in  NREQ*WIDTH: requester i's data in bits [i*WIDTH +: WIDTH].
- `clr`  in  1: synchronous clear request for `q`.
- `grant`  out  NREQ: one-hot grant; all zero when no requester owns the register.
- `ack`  out  NREQ: one-cycle pulse to the owner when its write has landed in `q`.
- `q`  out  WIDTH: the shared register contents.
- `owner`  out  $clog2(NREQ): index of the current or last owner.
- `busy`  out  1: high when the FSM is in any state other than IDLE.

## Operation

- States are IDLE, GRANT and HOLD. Internal state is `ptr` ($clog2(NREQ) bits) and `hcnt` (the HOLD counter).
- Reset (`reset`=0) sets state=IDLE, ptr=0, hcnt=0, `grant`=0, `ack`=0, `q`=0, `owner`=0 and `busy`=0. Reset acts asynchronously and takes effect mid-operation with no pending ack.
- Behaviour in IDLE:
  - If `clr`=1: `q`<=0 and the FSM stays in IDLE. `clr` has priority over `req`.
  - Else, if any `req` bit is 1: the winner is the first set bit found scanning ptr, ptr+1, …, wrapping modulo NREQ. The FSM sets `grant`<=onehot(winner), `owner`<=winner, and moves to GRANT.
- Behaviour in GRANT (exactly 1 cycle):
  - `q`<=wdata[owner], `ack`[owner]<=1, hcnt<=HOLD, and the FSM moves to HOLD.
  - The write completes even if `req`[owner] dropped during GRANT.
- Behaviour in HOLD:
  - `ack`<=0 and hcnt decrements each cycle.
  - When hcnt reaches 1: `grant`<=0, ptr<=(owner+1) mod NREQ, and the FSM moves to IDLE.
  - `q` is stable throughout HOLD.
- `clr` and `req` are sampled only in IDLE. A `clr` that is still held on return to IDLE takes effect then.
- A requester must drop `req` after seeing `ack`. If it keeps `req` high, it re-competes with the lowest priority.
- `wdata` of non-owners is ignored. `owner` retains its value after release.

## Timing

For a request sampled in IDLE at edge E:

- `grant` and `busy` rise after E.
- `q` updates after E+1, and `ack` is high for exactly the cycle between E+1 and E+2.
- `grant` and `busy` fall after E+1+HOLD.
- The earliest next grant is after E+2+HOLD.
- Service period under continuous contention is HOLD+2 cycles per write (4 cycles at the defaults).

Other timing rules:

- Worst-case wait for any requester that holds `req` is (NREQ-1)·(HOLD+2) cycles before its grant.
- `ack` is never asserted outside the first cycle after GRANT.
- `grant` is never more than one-hot.

## Test plan

- Async reset: drive `reset`=0 mid-HOLD, between clock edges → `grant`, `ack`, `q`, `owner` and `busy` all go to 0 immediately. After release, the first grant goes to requester 0 if it is requesting.
- Single request: `req`=0010, wdata[1]=0xA5, HOLD=2 → `grant`=0010 after edge 1; `q`=0xA5 and `ack`=0010 after edge 2 for one cycle; `grant`=0 and `busy`=0 after edge 4.
- Round-robin: `req`=1111 held constantly, all `wdata` distinct → grant order is 0,1,2,3,0, with grants spaced 4 cycles apart. Each `ack` is a single cycle, and `q` follows each owner's data.
- Clear priority: in IDLE with `q`=0x3C, `clr`=1 and `req`=0001 in the same cycle → `q`=0 and no grant that cycle. With `clr` dropped, `grant`=0001 follows after the next edge.
- Dropped request: `req`=0100 pulses for one cycle only → GRANT still completes, `q`=wdata[2], and `ack`=0100 pulses once.
- Pointer wrap: last owner=3, `req`=1001 → `grant`=0001. On the next contest, with `req`=1001 still held → `grant`=1000.
